// File: rtl/icache_prefetch_unpack.sv
// icache_prefetch_unpack
// Splits a packed 136-bit icache prefetch word into up to two 68-bit
// {length, data} entries (low half first) for the prefetch FIFO, and keeps a
// saturating count of bytes handed to the FIFO.
module icache_prefetch_unpack #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             line_valid,
  input  logic [135:0]     line_data,
  output logic             line_accept,
  output logic             prefetch_valid,
  output logic [67:0]      prefetch_data,
  input  logic             prefetch_accept,
  output logic             busy,
  output logic [CNT_W-1:0] bytes_delivered
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LO    = 2'd1,
    HI    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [67:0]      hi_q, hi_d;
  logic [67:0]      entry_q, entry_d;
  logic [CNT_W-1:0] bytes_q, bytes_d;

  logic [3:0]       in_lo_len;
  logic [3:0]       in_hi_len;
  logic [3:0]       held_hi_len;
  logic             fire;
  logic             completing;
  logic [CNT_W:0]   bytes_sum;

  // Out-of-range length codes 9..15 are treated as a full 8-byte half.
  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    return (len > 4'd8) ? 4'd8 : len;
  endfunction

  assign in_lo_len   = clamp_len(line_data[67:64]);
  assign in_hi_len   = clamp_len(line_data[135:132]);
  assign held_hi_len = clamp_len(hi_q[67:64]);

  assign prefetch_valid  = (state_q != EMPTY);
  assign busy            = (state_q != EMPTY);
  assign prefetch_data   = entry_q;
  assign bytes_delivered = bytes_q;

  assign fire       = prefetch_valid && prefetch_accept;
  assign completing = fire && ((state_q == HI) || ((state_q == LO) && (held_hi_len == 4'd0)));
  assign bytes_sum  = {1'b0, bytes_q} + {{(CNT_W-3){1'b0}}, entry_q[67:64]};

  // Next-state, handshake and counter logic; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    entry_d     = entry_q;
    bytes_d     = bytes_q;
    line_accept = rst_n && !flush && ((state_q == EMPTY) || completing);

    if (fire) begin
      bytes_d = bytes_sum[CNT_W] ? {CNT_W{1'b1}} : bytes_sum[CNT_W-1:0];
    end

    if (completing) begin
      state_d = EMPTY;
    end else if (fire && (state_q == LO)) begin
      state_d = HI;
      entry_d = {held_hi_len, hi_q[63:0]};
    end

    if (line_valid && line_accept) begin
      hi_d = line_data[135:68];
      if (in_lo_len != 4'd0) begin
        state_d = LO;
        entry_d = {in_lo_len, line_data[63:0]};
      end else if (in_hi_len != 4'd0) begin
        state_d = HI;
        entry_d = {in_hi_len, line_data[131:68]};
      end else begin
        state_d = EMPTY;
      end
    end

    if (flush) begin
      state_d = EMPTY;
      bytes_d = '0;
    end
  end

  // State, held high half, offered entry and byte counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      hi_q    <= '0;
      entry_q <= '0;
      bytes_q <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      entry_q <= entry_d;
      bytes_q <= bytes_d;
    end
  end

endmodule

// File: tb/tb_icache_prefetch_unpack.sv
// Directed self-checking bench for icache_prefetch_unpack.
module tb_icache_prefetch_unpack;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         line_valid;
  logic [135:0] line_data;
  logic         line_accept;
  logic         prefetch_valid;
  logic [67:0]  prefetch_data;
  logic         prefetch_accept;
  logic         busy;
  logic [15:0]  bytes_delivered;

  int checks;
  int failures;

  localparam logic [63:0] LO_FULL = 64'h0706050403020100;
  localparam logic [63:0] HI_FULL = 64'h0F0E0D0C0B0A0908;

  icache_prefetch_unpack #(.CNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .line_valid     (line_valid),
    .line_data      (line_data),
    .line_accept    (line_accept),
    .prefetch_valid (prefetch_valid),
    .prefetch_data  (prefetch_data),
    .prefetch_accept(prefetch_accept),
    .busy           (busy),
    .bytes_delivered(bytes_delivered)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    flush           = 1'b0;
    line_valid      = 1'b0;
    line_data       = '0;
    prefetch_accept = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (prefetch_valid !== 1'b0 || busy !== 1'b0 || prefetch_data !== 68'd0 ||
        bytes_delivered !== 16'd0 || line_accept !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset: valid=%b busy=%b data=%h bytes=%h accept=%b, want 0 0 0 0 1",
               prefetch_valid, busy, prefetch_data, bytes_delivered, line_accept);
    end
  endtask

  task automatic test_full_line();
    do_reset();
    prefetch_accept = 1'b1;
    line_valid      = 1'b1;
    line_data       = {4'd8, HI_FULL, 4'd8, LO_FULL};
    tick();
    line_valid = 1'b0;
    #1;
    checks++;
    if (prefetch_valid !== 1'b1 || prefetch_data !== {4'd8, LO_FULL} || line_accept !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_lo: valid=%b data=%h accept=%b, want 1 %h 0",
               prefetch_valid, prefetch_data, line_accept, {4'd8, LO_FULL});
    end
    tick();
    checks++;
    if (prefetch_valid !== 1'b1 || prefetch_data !== {4'd8, HI_FULL} || line_accept !== 1'b1) begin
      failures++;
      $display("[TB] FAIL full_hi: valid=%b data=%h accept=%b, want 1 %h 1",
               prefetch_valid, prefetch_data, line_accept, {4'd8, HI_FULL});
    end
    tick();
    checks++;
    if (prefetch_valid !== 1'b0 || bytes_delivered !== 16'd16 || prefetch_data !== {4'd8, HI_FULL}) begin
      failures++;
      $display("[TB] FAIL full_done: valid=%b bytes=%0d data=%h, want 0 16 %h",
               prefetch_valid, bytes_delivered, prefetch_data, {4'd8, HI_FULL});
    end
  endtask

  task automatic test_partial_lo();
    do_reset();
    prefetch_accept = 1'b1;
    line_valid      = 1'b1;
    line_data       = {4'd0, 64'h1111_2222_3333_4444, 4'd3, 64'h0000_0000_00CC_BBAA};
    tick();
    line_valid = 1'b0;
    #1;
    checks++;
    if (prefetch_valid !== 1'b1 || prefetch_data !== {4'd3, 64'h0000_0000_00CC_BBAA} || line_accept !== 1'b1) begin
      failures++;
      $display("[TB] FAIL partial_entry: valid=%b data=%h accept=%b, want 1 3_00000000_00ccbbaa 1",
               prefetch_valid, prefetch_data, line_accept);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || prefetch_valid !== 1'b0 || bytes_delivered !== 16'd3) begin
      failures++;
      $display("[TB] FAIL partial_done: busy=%b valid=%b bytes=%0d, want 0 0 3",
               busy, prefetch_valid, bytes_delivered);
    end
  endtask

  task automatic test_stall();
    int bad;
    do_reset();
    prefetch_accept = 1'b0;
    line_valid      = 1'b1;
    line_data       = {4'd8, HI_FULL, 4'd8, LO_FULL};
    tick();
    line_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (prefetch_valid !== 1'b1 || prefetch_data !== {4'd8, LO_FULL} || line_accept !== 1'b0)
        bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL stall_hold: %0d bad cycles, want 0", bad);
    end
    checks++;
    if (bytes_delivered !== 16'd0) begin
      failures++;
      $display("[TB] FAIL stall_count: bytes=%0d, want 0", bytes_delivered);
    end
    prefetch_accept = 1'b1;
    tick();
    checks++;
    if (prefetch_valid !== 1'b1 || prefetch_data !== {4'd8, HI_FULL}) begin
      failures++;
      $display("[TB] FAIL stall_release_hi: valid=%b data=%h, want 1 %h",
               prefetch_valid, prefetch_data, {4'd8, HI_FULL});
    end
    tick();
    checks++;
    if (prefetch_valid !== 1'b0 || bytes_delivered !== 16'd16) begin
      failures++;
      $display("[TB] FAIL stall_release_done: valid=%b bytes=%0d, want 0 16",
               prefetch_valid, bytes_delivered);
    end
  endtask

  task automatic test_back_to_back();
    logic [67:0] exp_q[$];
    int idx;
    int entries;
    int first_cyc;
    int last_cyc;
    int bad;
    logic acc;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({4'd8, 64'hA0A0_0000_0000_0000 | 64'(k)});
      exp_q.push_back({4'd8, 64'hB0B0_0000_0000_0000 | 64'(k)});
    end
    prefetch_accept = 1'b1;
    idx = 0; entries = 0; first_cyc = -1; last_cyc = -1; bad = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      line_valid = (idx < 4);
      line_data  = {4'd8, 64'hB0B0_0000_0000_0000 | 64'(idx), 4'd8, 64'hA0A0_0000_0000_0000 | 64'(idx)};
      #1;
      acc = line_valid && line_accept;
      if (prefetch_valid) begin
        if (entries < 8 && prefetch_data !== exp_q[entries]) bad++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        entries++;
      end
      tick();
      if (acc) idx++;
    end
    line_valid = 1'b0;
    checks++;
    if (entries != 8 || (last_cyc - first_cyc) != 7) begin
      failures++;
      $display("[TB] FAIL stream_gapless: entries=%0d span=%0d, want 8 7", entries, last_cyc - first_cyc);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL stream_data: %0d wrong entries, want 0", bad);
    end
    checks++;
    if (bytes_delivered !== 16'd64) begin
      failures++;
      $display("[TB] FAIL stream_bytes: bytes=%0d, want 64", bytes_delivered);
    end
  endtask

  task automatic test_flush();
    do_reset();
    prefetch_accept = 1'b1;
    line_valid      = 1'b1;
    line_data       = {4'd8, HI_FULL, 4'd8, LO_FULL};
    tick();
    line_valid = 1'b0;
    tick();
    flush      = 1'b1;
    line_valid = 1'b1;
    line_data  = {4'd0, 64'd0, 4'd5, 64'h0000_0055_4433_2211};
    #1;
    checks++;
    if (line_accept !== 1'b0 || prefetch_valid !== 1'b1 || bytes_delivered !== 16'd8) begin
      failures++;
      $display("[TB] FAIL flush_cycle: accept=%b valid=%b bytes=%0d, want 0 1 8",
               line_accept, prefetch_valid, bytes_delivered);
    end
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (prefetch_valid !== 1'b0 || bytes_delivered !== 16'd0 || line_accept !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_after: valid=%b bytes=%0d accept=%b, want 0 0 1",
               prefetch_valid, bytes_delivered, line_accept);
    end
    tick();
    line_valid = 1'b0;
    #1;
    checks++;
    if (prefetch_valid !== 1'b1 || prefetch_data !== {4'd5, 64'h0000_0055_4433_2211}) begin
      failures++;
      $display("[TB] FAIL flush_next_word: valid=%b data=%h, want 1 5_00000055_44332211",
               prefetch_valid, prefetch_data);
    end
    tick();
  endtask

  task automatic test_edges();
    do_reset();
    prefetch_accept = 1'b1;
    line_valid      = 1'b1;
    line_data       = {4'd0, 64'd0, 4'd12, 64'hDEAD_BEEF_CAFE_F00D};
    tick();
    line_valid = 1'b0;
    #1;
    checks++;
    if (prefetch_data !== {4'd8, 64'hDEAD_BEEF_CAFE_F00D}) begin
      failures++;
      $display("[TB] FAIL clamp_len: data=%h, want 8_deadbeef_cafef00d", prefetch_data);
    end
    tick();
    checks++;
    if (bytes_delivered !== 16'd8) begin
      failures++;
      $display("[TB] FAIL clamp_count: bytes=%0d, want 8", bytes_delivered);
    end
    line_valid = 1'b1;
    line_data  = {4'd0, 64'h1234, 4'd0, 64'h5678};
    tick();
    line_valid = 1'b0;
    #1;
    checks++;
    if (prefetch_valid !== 1'b0 || busy !== 1'b0 || line_accept !== 1'b1 || bytes_delivered !== 16'd8) begin
      failures++;
      $display("[TB] FAIL zero_word: valid=%b busy=%b accept=%b bytes=%0d, want 0 0 1 8",
               prefetch_valid, busy, line_accept, bytes_delivered);
    end
  endtask

  task automatic test_saturate();
    int words;
    int cyc;
    logic acc;
    do_reset();
    prefetch_accept = 1'b1;
    line_valid      = 1'b1;
    words = 0;
    cyc   = 0;
    while (words < 4096 && cyc < 9000) begin
      line_data = (words == 4095) ? {4'd6, HI_FULL, 4'd8, LO_FULL} : {4'd8, HI_FULL, 4'd8, LO_FULL};
      #1;
      acc = line_accept;
      tick();
      if (acc) words++;
      cyc++;
    end
    line_valid = 1'b0;
    checks++;
    if (words != 4096) begin
      failures++;
      $display("[TB] FAIL sat_feed_timeout: words=%0d, want 4096", words);
    end
    cyc = 0;
    while (busy && cyc < 10) begin
      tick();
      cyc++;
    end
    checks++;
    if (busy !== 1'b0 || bytes_delivered !== 16'hFFFE) begin
      failures++;
      $display("[TB] FAIL sat_pre: busy=%b bytes=%h, want 0 fffe", busy, bytes_delivered);
    end
    line_valid = 1'b1;
    line_data  = {4'd0, 64'd0, 4'd8, LO_FULL};
    tick();
    line_valid = 1'b0;
    tick();
    checks++;
    if (bytes_delivered !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL sat_cap: bytes=%h, want ffff", bytes_delivered);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    prefetch_accept = 1'b1;
    line_valid      = 1'b1;
    line_data       = {4'd0, 64'd0, 4'd8, LO_FULL};
    tick();
    line_valid = 1'b1;
    line_data  = {4'd8, HI_FULL, 4'd8, LO_FULL};
    prefetch_accept = 1'b1;
    tick();
    line_valid      = 1'b0;
    prefetch_accept = 1'b0;
    #1;
    checks++;
    if (prefetch_valid !== 1'b1 || bytes_delivered !== 16'd8) begin
      failures++;
      $display("[TB] FAIL areset_setup: valid=%b bytes=%0d, want 1 8", prefetch_valid, bytes_delivered);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (prefetch_valid !== 1'b0 || busy !== 1'b0 || prefetch_data !== 68'd0 ||
        bytes_delivered !== 16'd0 || line_accept !== 1'b0) begin
      failures++;
      $display("[TB] FAIL areset_outputs: valid=%b busy=%b data=%h bytes=%0d accept=%b, want all 0",
               prefetch_valid, busy, prefetch_data, bytes_delivered, line_accept);
    end
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  // Run every scenario in order, then report.
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_full_line();
    test_partial_lo();
    test_stall();
    test_back_to_back();
    test_flush();
    test_edges();
    test_saturate();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
